multi_synapse_neuron: RTL and testbench

MULTI_SYNAPSE_NEURON -- requirements
Module: multi_synapse_neuron

---
 rtl/neuron_pkg.sv | 20 ++
 rtl/weighted_spike_sum.sv | 26 ++
 rtl/multi_synapse_neuron.sv | 135 +++++++++++++
 tb/tb_multi_synapse_neuron.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and default constants for the multi-synapse neuron.
// State encoding plus the parameter defaults used by top and sub-blocks.
package neuron_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_INTEGRATE  = 2'd0;
  localparam state_t ST_FIRE       = 2'd1;
  localparam state_t ST_REFRACTORY = 2'd2;

  localparam int DEF_WIDTH          = 10;
  localparam int DEF_N_INPUTS       = 4;
  localparam int DEF_WEIGHT_W       = 6;
  localparam int DEF_THRESHOLD      = 500;
  localparam int DEF_BASE           = 100;
  localparam int DEF_RESET_V        = 80;
  localparam int DEF_LEAK_SHIFT     = 4;
  localparam int DEF_REFRACT_CYCLES = 8;

endpackage

// File: rtl/weighted_spike_sum.sv
// Combinational sum of the weights of all currently asserted synapses.
// Result width leaves headroom so the sum can never overflow.
module weighted_spike_sum
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = DEF_N_INPUTS,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  localparam int SUM_W =
    WEIGHT_W + $clog2(N_INPUTS) + 1
) (
  input  logic [N_INPUTS-1:0]          spikes,
  input  logic [N_INPUTS*WEIGHT_W-1:0] weights,
  output logic [SUM_W-1:0]             sum
);

  always_comb begin
    sum = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (spikes[k]) begin
        sum = sum + SUM_W'(
          weights[k*WEIGHT_W +: WEIGHT_W]);
      end
    end
  end

endmodule

// File: rtl/multi_synapse_neuron.sv
// Leaky integrate-and-fire neuron with weighted synapses,
// a one-cycle fire pulse and a fixed-length refractory window.
module multi_synapse_neuron
  import neuron_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int N_INPUTS       = DEF_N_INPUTS,
  parameter int WEIGHT_W       = DEF_WEIGHT_W,
  parameter int THRESHOLD      = DEF_THRESHOLD,
  parameter int BASE           = DEF_BASE,
  parameter int RESET_V        = DEF_RESET_V,
  parameter int LEAK_SHIFT     = DEF_LEAK_SHIFT,
  parameter int REFRACT_CYCLES = DEF_REFRACT_CYCLES
) (
  input  logic                         i_Clk,
  input  logic                         i_Reset,
  input  logic [N_INPUTS-1:0]          i_Spikes,
  input  logic [N_INPUTS*WEIGHT_W-1:0] i_Weights,
  output logic [WIDTH-1:0]             o_Potential,
  output logic                         o_Spike,
  output logic                         o_Refractory,
  output logic [15:0]                  o_Spike_Count
);

  localparam int SUM_W =
    WEIGHT_W + $clog2(N_INPUTS) + 1;
  localparam int ADD_W =
    ((WIDTH > SUM_W) ? WIDTH : SUM_W) + 1;
  localparam int CNT_W = (REFRACT_CYCLES > 0) ?
    $clog2(REFRACT_CYCLES + 1) : 1;

  localparam logic [WIDTH-1:0] MAX_V   = '1;
  localparam logic [WIDTH-1:0] BASE_V  = WIDTH'(BASE);
  localparam logic [WIDTH-1:0] THR_V   = WIDTH'(THRESHOLD);
  localparam logic [WIDTH-1:0] RESET_P = WIDTH'(RESET_V);
  localparam logic [CNT_W-1:0] RC_V    =
    CNT_W'(REFRACT_CYCLES);

  state_t             state;
  logic [CNT_W-1:0]   refr_cnt;
  logic [SUM_W-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   leak_step;
  logic [WIDTH-1:0]   leaked;
  logic [ADD_W-1:0]   raw;
  logic [WIDTH-1:0]   next_int;
  logic               fire_now;

  weighted_spike_sum #(
    .N_INPUTS (N_INPUTS),
    .WEIGHT_W (WEIGHT_W)
  ) u_sum (
    .spikes  (i_Spikes),
    .weights (i_Weights),
    .sum     (sum)
  );

  // Leak toward BASE, always moving at least one step.
  always_comb begin
    diff      = '0;
    leak_step = '0;
    leaked    = o_Potential;
    if (o_Potential > BASE_V) begin
      diff      = o_Potential - BASE_V;
      leak_step = diff >> LEAK_SHIFT;
      if (leak_step == '0) leak_step = WIDTH'(1);
      leaked    = o_Potential - leak_step;
    end else if (o_Potential < BASE_V) begin
      diff      = BASE_V - o_Potential;
      leak_step = diff >> LEAK_SHIFT;
      if (leak_step == '0) leak_step = WIDTH'(1);
      leaked    = o_Potential + leak_step;
    end
  end

  always_comb begin
    raw = ADD_W'(o_Potential) + ADD_W'(sum);
    if (sum == '0) begin
      next_int = leaked;
    end else if (raw > ADD_W'(MAX_V)) begin
      next_int = MAX_V;
    end else begin
      next_int = raw[WIDTH-1:0];
    end
    fire_now = (next_int >= THR_V);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state         <= ST_INTEGRATE;
      refr_cnt      <= '0;
      o_Potential   <= BASE_V;
      o_Spike       <= 1'b0;
      o_Refractory  <= 1'b0;
      o_Spike_Count <= 16'd0;
    end else begin
      unique case (state)
        ST_INTEGRATE: begin
          o_Potential <= next_int;
          if (fire_now) begin
            o_Spike       <= 1'b1;
            o_Spike_Count <= o_Spike_Count + 16'd1;
            state         <= ST_FIRE;
          end
        end
        ST_FIRE: begin
          o_Spike     <= 1'b0;
          o_Potential <= RESET_P;
          if (REFRACT_CYCLES == 0) begin
            state <= ST_INTEGRATE;
          end else begin
            state        <= ST_REFRACTORY;
            o_Refractory <= 1'b1;
            refr_cnt     <= RC_V;
          end
        end
        ST_REFRACTORY: begin
          o_Potential <= leaked;
          refr_cnt    <= refr_cnt - CNT_W'(1);
          if (refr_cnt == CNT_W'(1)) begin
            state        <= ST_INTEGRATE;
            o_Refractory <= 1'b0;
          end
        end
        default: begin
          state        <= ST_INTEGRATE;
          o_Spike      <= 1'b0;
          o_Refractory <= 1'b0;
          refr_cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_synapse_neuron.sv
// Bench: three neuron variants driven in lockstep,
// each checked every cycle against an arithmetic model.
module tb_multi_synapse_neuron;

  localparam int NI = 4;
  localparam int WW = 6;
  localparam int W  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NI-1:0]    sp;
  logic [NI*WW-1:0] wt;

  logic [W-1:0] pot0, pot1, pot2;
  logic         spk0, spk1, spk2;
  logic         rfr0, rfr1, rfr2;
  logic [15:0]  cnt0, cnt1, cnt2;

  multi_synapse_neuron u_dut0 (
    .i_Clk(clk), .i_Reset(rst),
    .i_Spikes(sp), .i_Weights(wt),
    .o_Potential(pot0), .o_Spike(spk0),
    .o_Refractory(rfr0), .o_Spike_Count(cnt0)
  );

  multi_synapse_neuron #(.THRESHOLD(1000)) u_dut1 (
    .i_Clk(clk), .i_Reset(rst),
    .i_Spikes(sp), .i_Weights(wt),
    .o_Potential(pot1), .o_Spike(spk1),
    .o_Refractory(rfr1), .o_Spike_Count(cnt1)
  );

  multi_synapse_neuron #(.REFRACT_CYCLES(0)) u_dut2 (
    .i_Clk(clk), .i_Reset(rst),
    .i_Spikes(sp), .i_Weights(wt),
    .o_Potential(pot2), .o_Spike(spk2),
    .o_Refractory(rfr2), .o_Spike_Count(cnt2)
  );

  int thr[3] = '{500, 1000, 500};
  int rc[3]  = '{8, 8, 0};
  int mv[3];
  int mleft[3];
  int mcnt[3];
  int mfire[3];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input int obs,
                       input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, obs, exp);
    end
  endtask

  function automatic int leak(input int v);
    int d;
    if (v > 100) begin
      d = (v - 100) / 16;
      if (d < 1) d = 1;
      return v - d;
    end
    if (v < 100) begin
      d = (100 - v) / 16;
      if (d < 1) d = 1;
      return v + d;
    end
    return v;
  endfunction

  function automatic int wsum();
    int s = 0;
    for (int k = 0; k < NI; k++)
      if (sp[k]) s += int'(wt[k*WW +: WW]);
    return s;
  endfunction

  task automatic model_step();
    int s, nv;
    s = wsum();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mv[i] = 100; mleft[i] = 0;
        mcnt[i] = 0; mfire[i] = 0;
      end else if (mfire[i] != 0) begin
        mv[i] = 80; mfire[i] = 0;
        mleft[i] = rc[i];
      end else if (mleft[i] > 0) begin
        mv[i] = leak(mv[i]);
        mleft[i]--;
      end else begin
        nv = (s > 0) ? mv[i] + s : leak(mv[i]);
        if (nv > 1023) nv = 1023;
        mv[i] = nv;
        if (nv >= thr[i]) begin
          mfire[i] = 1;
          mcnt[i] = (mcnt[i] + 1) % 65536;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("pot0", int'(pot0), mv[0]);
    check("spk0", int'(spk0), mfire[0]);
    check("rfr0", int'(rfr0), int'(mleft[0] > 0));
    check("cnt0", int'(cnt0), mcnt[0]);
    check("pot1", int'(pot1), mv[1]);
    check("spk1", int'(spk1), mfire[1]);
    check("rfr1", int'(rfr1), int'(mleft[1] > 0));
    check("cnt1", int'(cnt1), mcnt[1]);
    check("pot2", int'(pot2), mv[2]);
    check("spk2", int'(spk2), mfire[2]);
    check("rfr2", int'(rfr2), int'(mleft[2] > 0));
    check("cnt2", int'(cnt2), mcnt[2]);
  endtask

  task automatic cycle(input logic r,
                       input logic [NI-1:0] s,
                       input logic [NI*WW-1:0] w);
    @(negedge clk);
    rst = r; sp = s; wt = w;
    @(posedge clk);
    #1;
    model_step();
    compare_all();
  endtask

  logic [NI*WW-1:0] all63;
  logic [NI*WW-1:0] w50;
  logic [NI*WW-1:0] rw;
  bit found;

  initial begin
    all63 = {NI{6'd63}};
    w50   = {18'd0, 6'd50};
    rst = 1'b1; sp = '0; wt = '0;

    cycle(1'b1, '0, '0);
    cycle(1'b1, '0, '0);
    check("rst_pot", int'(pot0), 100);
    check("rst_spk", int'(spk0), 0);
    check("rst_rfr", int'(rfr0), 0);
    check("rst_cnt", int'(cnt0), 0);

    repeat (3) cycle(1'b0, '0, all63);
    check("idle", int'(pot0), 100);
    cycle(1'b0, 4'b0001, w50);
    check("w50", int'(pot0), 150);
    cycle(1'b0, '0, w50);
    check("leak1", int'(pot0), 147);
    cycle(1'b0, '0, w50);
    check("leak2", int'(pot0), 145);

    cycle(1'b1, '0, '0);
    cycle(1'b0, 4'hF, all63);
    check("int352", int'(pot0), 352);
    cycle(1'b0, 4'hF, all63);
    check("peak", int'(pot0), 604);
    check("fire", int'(spk0), 1);
    check("fcnt", int'(cnt0), 1);
    cycle(1'b0, 4'hF, all63);
    check("rstv", int'(pot0), 80);
    check("rfr_on", int'(rfr0), 1);
    check("r0_rfr", int'(rfr2), 0);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 4'hF, all63);
      check("refr_pot", int'(pot0), 81 + k);
      check("refr_flag", int'(rfr0), int'(k < 7));
      if (k == 0) begin
        check("sat_pot", int'(pot1), 1023);
        check("sat_fire", int'(spk1), 1);
        check("r0_accept", int'(pot2), 332);
      end
    end
    cycle(1'b0, 4'hF, all63);
    check("post_refr", int'(pot0), 340);

    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      cycle(1'b0, 4'hF, all63);
      if (mleft[0] == 6) found = 1'b1;
    end
    check("refr3_reach", int'(found), 1);
    cycle(1'b1, 4'hF, all63);
    check("mid_rst_pot", int'(pot0), 100);
    check("mid_rst_rfr", int'(rfr0), 0);
    check("mid_rst_cnt", int'(cnt0), 0);
    cycle(1'b0, 4'b0001, w50);
    check("after_rst", int'(pot0), 150);

    for (int t = 0; t < 3000; t++) begin
      rw = NI*WW'($urandom);
      if ($urandom_range(0, 2) == 0)
        rw = rw & {NI{6'h0F}};
      cycle($urandom_range(0, 199) == 0,
            NI'($urandom), rw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
